// File: rtl/gem_cluster_pkg.sv
// Shared cluster definitions for the GEM cluster packer/unpacker pair.
// A cluster is {cnt = size-1, adr = first strip}; adr at or beyond N_STRIPS means "no cluster".
package gem_cluster_pkg;
  localparam int N_VFATS       = 24;
  localparam int N_STRIPS      = 64 * N_VFATS;
  localparam int N_CLUSTERS    = 8;
  localparam int CLUST_PER_CYC = 2;
  localparam int N_PHASES      = N_CLUSTERS / CLUST_PER_CYC;
  localparam int PHASE_W       = $clog2(N_PHASES);
  localparam int IDX_W         = $clog2(N_CLUSTERS);
  localparam int ADR_W         = 11;
  localparam int CNT_W         = 3;
  localparam int CLUSTER_W     = ADR_W + CNT_W;
  localparam logic [ADR_W-1:0] NULL_ADR = 11'h7FF;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [ADR_W-1:0] adr;
  } cluster_t;

  localparam cluster_t NULL_CLUSTER = '{cnt: '0, adr: NULL_ADR};

  typedef enum logic {
    ST_IDLE,
    ST_EXPAND
  } state_e;
endpackage

// File: rtl/cluster_expander.sv
// Combinational expansion of one cluster into a strip mask.
// The run is built at the bottom of a full-width vector, so strips past the map end simply shift out.
module cluster_expander
  import gem_cluster_pkg::*;
(
  input  cluster_t              cluster,
  output logic [N_STRIPS-1:0]   mask,
  output logic                  valid
);
  localparam int MAX_RUN = 1 << CNT_W;

  logic [N_STRIPS-1:0] run;

  always_comb begin
    valid = cluster.adr < ADR_W'(N_STRIPS);
    run = '0;
    run[MAX_RUN-1:0] = {MAX_RUN{1'b1}} >> (CNT_W'(MAX_RUN - 1) - cluster.cnt);
    mask = valid ? (run << cluster.adr) : '0;
  end
endmodule

// File: rtl/cluster_unpacker.sv
// Rebuilds the strip map of one bunch crossing from its packed clusters, CLUST_PER_CYC per cycle,
// and publishes it N_PHASES cycles after the strobe.
module cluster_unpacker
  import gem_cluster_pkg::*;
(
  input  logic                            clock4x,
  input  logic                            global_reset,
  input  logic [N_CLUSTERS*CLUSTER_W-1:0] clusters,
  input  logic                            clusters_valid,
  output logic [N_STRIPS-1:0]             sbits,
  output logic                            sbits_valid,
  output logic [3:0]                      n_clusters,
  output logic                            overrun,
  output state_e                          dbg_state
);
  // clusters_valid is a one-cycle strobe with no ready: the frame is captured on that edge and
  // must not be re-offered. A strobe on the last expansion edge is back-to-back and legal; a
  // strobe on any earlier expansion edge aborts the frame in flight and raises overrun.
  state_e                          state_q, state_d;
  logic [PHASE_W-1:0]              phase_q, phase_d;
  cluster_t [N_CLUSTERS-1:0]       hold_q, hold_d;
  logic [N_STRIPS-1:0]             acc_q, acc_d;
  logic [3:0]                      cnt_q, cnt_d;
  logic [N_STRIPS-1:0]             sbits_q, sbits_d;
  logic [3:0]                      n_clusters_q, n_clusters_d;
  logic                            sbits_valid_q, sbits_valid_d;
  logic                            overrun_q, overrun_d;

  cluster_t                        grp [CLUST_PER_CYC];
  logic [N_STRIPS-1:0]             mask [CLUST_PER_CYC];
  logic [CLUST_PER_CYC-1:0]        vld;
  logic [N_STRIPS-1:0]             exp_or;
  logic [3:0]                      grp_cnt;
  logic                            last_phase;

  always_comb begin
    for (int g = 0; g < CLUST_PER_CYC; g++) begin
      grp[g] = hold_q[IDX_W'(int'(phase_q) * CLUST_PER_CYC + g)];
    end
  end

  for (genvar g = 0; g < CLUST_PER_CYC; g++) begin : g_exp
    cluster_expander u_expander (
      .cluster (grp[g]),
      .mask    (mask[g]),
      .valid   (vld[g])
    );
  end

  always_comb begin
    exp_or  = '0;
    grp_cnt = '0;
    for (int g = 0; g < CLUST_PER_CYC; g++) begin
      exp_or  = exp_or | mask[g];
      grp_cnt = grp_cnt + 4'(vld[g]);
    end
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    hold_d        = hold_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    sbits_d       = sbits_q;
    n_clusters_d  = n_clusters_q;
    sbits_valid_d = 1'b0;
    overrun_d     = 1'b0;
    last_phase    = (state_q == ST_EXPAND) && (phase_q == PHASE_W'(N_PHASES - 1));

    if (state_q == ST_EXPAND) begin
      acc_d   = (phase_q == '0) ? exp_or : (acc_q | exp_or);
      cnt_d   = (phase_q == '0) ? grp_cnt : (cnt_q + grp_cnt);
      phase_d = phase_q + 1'b1;
      if (last_phase) begin
        sbits_d       = acc_q | exp_or;
        n_clusters_d  = cnt_q + grp_cnt;
        sbits_valid_d = 1'b1;
        state_d       = ST_IDLE;
      end
    end

    // The last group was already read from hold_q above, so overwriting it here is safe.
    if (clusters_valid) begin
      overrun_d = (state_q == ST_EXPAND) && !last_phase;
      hold_d    = clusters;
      phase_d   = '0;
      acc_d     = '0;
      cnt_d     = '0;
      state_d   = ST_EXPAND;
    end
  end

  always_ff @(posedge clock4x) begin
    if (global_reset) begin
      state_q       <= ST_IDLE;
      phase_q       <= '0;
      for (int k = 0; k < N_CLUSTERS; k++) hold_q[k] <= NULL_CLUSTER;
      acc_q         <= '0;
      cnt_q         <= '0;
      sbits_q       <= '0;
      n_clusters_q  <= '0;
      sbits_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      hold_q        <= hold_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      sbits_q       <= sbits_d;
      n_clusters_q  <= n_clusters_d;
      sbits_valid_q <= sbits_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign sbits       = sbits_q;
  assign sbits_valid = sbits_valid_q;
  assign n_clusters  = n_clusters_q;
  assign overrun     = overrun_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_cluster_unpacker.sv
// Bench for cluster_unpacker: directed vector table, timing sequences and randomized frames
// checked every cycle against a frame-level reference model.
module tb_cluster_unpacker;
  import gem_cluster_pkg::*;

  localparam int NS  = 1536;
  localparam int CW  = 112;
  localparam int LAT = 4;

  logic            clock4x = 1'b0;
  logic            global_reset;
  logic [CW-1:0]   clusters;
  logic            clusters_valid;
  logic [NS-1:0]   sbits;
  logic            sbits_valid;
  logic [3:0]      n_clusters;
  logic            overrun;
  state_e          dbg_state;

  int total = 0;
  int bad   = 0;
  int n_pulses = 0;
  int n_ovr    = 0;

  // Reference model state: one frame in flight with its age in cycles since the strobe.
  logic            m_active = 1'b0;
  int              m_age = 0;
  logic [NS-1:0]   m_map = '0;
  int              m_n = 0;
  logic [NS-1:0]   e_sbits = '0;
  int              e_n = 0;
  logic            e_valid = 1'b0;
  logic            e_ovr = 1'b0;

  cluster_unpacker dut (
    .clock4x        (clock4x),
    .global_reset   (global_reset),
    .clusters       (clusters),
    .clusters_valid (clusters_valid),
    .sbits          (sbits),
    .sbits_valid    (sbits_valid),
    .n_clusters     (n_clusters),
    .overrun        (overrun),
    .dbg_state      (dbg_state)
  );

  always #3 clock4x = ~clock4x;

  function automatic logic [CW-1:0] put(input logic [CW-1:0] cl, input int k,
                                        input logic [2:0] c, input logic [10:0] a);
    cl[14*k +: 14] = {c, a};
    return cl;
  endfunction

  function automatic logic [CW-1:0] all_null();
    logic [CW-1:0] cl;
    for (int k = 0; k < 8; k++) cl[14*k +: 14] = {3'd0, 11'h7FF};
    return cl;
  endfunction

  // Each cluster covers strips adr..adr+cnt, clipped at the map end; out-of-range adr is absent.
  task automatic ref_expand(input logic [CW-1:0] cl, output logic [NS-1:0] map, output int n);
    map = '0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      int adr, cnt;
      cnt = int'(cl[14*k + 11 +: 3]);
      adr = int'(cl[14*k +: 11]);
      if (adr < NS) begin
        n++;
        for (int j = 0; j <= cnt; j++) if (adr + j < NS) map[adr + j] = 1'b1;
      end
    end
  endtask

  task automatic model_edge(input logic rst, input logic vld, input logic [CW-1:0] cl);
    if (rst) begin
      m_active = 1'b0;
      e_sbits  = '0;
      e_n      = 0;
      e_valid  = 1'b0;
      e_ovr    = 1'b0;
    end else begin
      e_valid = 1'b0;
      e_ovr   = 1'b0;
      if (m_active) begin
        m_age++;
        if (m_age == LAT) begin
          e_sbits  = m_map;
          e_n      = m_n;
          e_valid  = 1'b1;
          m_active = 1'b0;
        end
      end
      if (vld) begin
        e_ovr    = m_active;
        m_active = 1'b1;
        m_age    = 0;
        ref_expand(cl, m_map, m_n);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_map(input string name, input logic [NS-1:0] act, input logic [NS-1:0] exp);
    total++;
    if (act !== exp) begin
      int first;
      first = -1;
      for (int i = NS - 1; i >= 0; i--) if (act[i] !== exp[i]) first = i;
      bad++;
      $display("FAIL %s: strip %0d got %b expected %b (popcount got %0d expected %0d) at %0t",
               name, first, act[first], exp[first], $countones(act), $countones(exp), $time);
    end
  endtask

  task automatic step(input logic rst, input logic vld, input logic [CW-1:0] cl);
    global_reset   = rst;
    clusters_valid = vld;
    clusters       = cl;
    @(posedge clock4x);
    model_edge(rst, vld, cl);
    #1;
    if (sbits_valid === 1'b1) n_pulses++;
    if (overrun === 1'b1) n_ovr++;
    chk("sbits_valid", int'(sbits_valid), int'(e_valid));
    chk("overrun", int'(overrun), int'(e_ovr));
    chk("n_clusters", int'(n_clusters), e_n);
    chk_map("sbits", sbits, e_sbits);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, all_null());
  endtask

  typedef struct {
    logic [CW-1:0] cl;
    logic [NS-1:0] map;
    int            n;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [CW-1:0] cl, cla, clb;
    logic [NS-1:0] tmp;
    int p0, o0;

    // Directed table: expected maps written from the cluster rules, independent of the model.
    cl = put(all_null(), 0, 3'd3, 11'd5);
    vecs[0] = '{cl: cl, map: 1536'h1E0, n: 1};
    cl = put(put(put(all_null(), 0, 3'd7, 11'd1534), 1, 3'd0, 11'd1536), 2, 3'd0, 11'd0);
    tmp = '0; tmp[0] = 1'b1; tmp[1534] = 1'b1; tmp[1535] = 1'b1;
    vecs[1] = '{cl: cl, map: tmp, n: 2};
    cl = put(put(all_null(), 0, 3'd2, 11'd10), 7, 3'd4, 11'd11);
    vecs[2] = '{cl: cl, map: 1536'hFC00, n: 2};
    vecs[3] = '{cl: all_null(), map: '0, n: 0};
    cl = put(put(all_null(), 3, 3'd7, 11'd1468), 5, 3'd7, 11'h7FF);
    tmp = '0; for (int i = 1468; i <= 1475; i++) tmp[i] = 1'b1;
    vecs[4] = '{cl: cl, map: tmp, n: 1};
    cl = all_null(); tmp = '0;
    for (int k = 0; k < 8; k++) begin
      cl = put(cl, k, 3'd0, 11'(100 * k));
      tmp[100 * k] = 1'b1;
    end
    vecs[5] = '{cl: cl, map: tmp, n: 8};

    // Reset held three cycles with strobes present: nothing may start.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, vecs[0].cl);
    chk("reset_state", int'(dbg_state), int'(ST_IDLE));
    p0 = n_pulses;
    idle(6);
    chk("reset_no_publish", n_pulses - p0, 0);

    for (int v = 0; v < 6; v++) begin
      step(1'b0, 1'b1, vecs[v].cl);
      idle(LAT);
      chk_map($sformatf("table%0d_map", v), sbits, vecs[v].map);
      chk($sformatf("table%0d_n", v), int'(n_clusters), vecs[v].n);
      idle(2);
    end

    // Back-to-back frames: strobe B on A's publish edge.
    cla = vecs[0].cl; clb = vecs[2].cl;
    p0 = n_pulses; o0 = n_ovr;
    step(1'b0, 1'b1, cla);
    idle(LAT - 1);
    step(1'b0, 1'b1, clb);
    chk_map("b2b_first_map", sbits, vecs[0].map);
    idle(LAT);
    chk_map("b2b_second_map", sbits, vecs[2].map);
    chk("b2b_pulses", n_pulses - p0, 2);
    chk("b2b_overruns", n_ovr - o0, 0);
    idle(2);

    // Early strobe two cycles after A: A discarded, only B published.
    p0 = n_pulses; o0 = n_ovr;
    step(1'b0, 1'b1, vecs[1].cl);
    idle(1);
    step(1'b0, 1'b1, vecs[4].cl);
    chk("early_overrun", int'(overrun), 1);
    idle(LAT);
    chk_map("early_map", sbits, vecs[4].map);
    chk("early_pulses", n_pulses - p0, 1);
    chk("early_overruns", n_ovr - o0, 1);
    idle(2);

    // Reset mid-frame: the frame in flight is never published.
    p0 = n_pulses;
    step(1'b0, 1'b1, vecs[5].cl);
    idle(2);
    step(1'b1, 1'b0, all_null());
    idle(LAT + 2);
    chk("midreset_pulses", n_pulses - p0, 0);
    chk("midreset_n", int'(n_clusters), 0);

    // Randomized frames with random spacing and occasional resets.
    for (int it = 0; it < 600; it++) begin
      logic rst, vld;
      cl = all_null();
      for (int k = 0; k < 8; k++) begin
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 5)
          cl = put(cl, k, 3'($urandom_range(0, 7)), 11'($urandom_range(0, NS - 1)));
        else if (r < 7)
          cl = put(cl, k, 3'($urandom_range(0, 7)), 11'($urandom_range(NS - 10, NS - 1)));
        else if (r < 8)
          cl = put(cl, k, 3'($urandom_range(0, 7)), 11'($urandom_range(NS, 2047)));
      end
      rst = ($urandom_range(0, 49) == 0);
      vld = ($urandom_range(0, 9) < 3);
      step(rst, vld, cl);
    end
    idle(LAT + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
